// File: rtl/mul_arb_pkg.sv
// Shared types for the two-requester multiplier front-end: FSM states,
// the latched request record and the requester count.
package mul_arb_pkg;

    localparam int NUM_REQ  = 2;
    localparam int MUL_XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    // Operand fields are sized by MUL_XLEN; the top's XLEN defaults to it.
    typedef struct packed {
        logic [1:0]          sign;
        logic                hi;
        logic [MUL_XLEN-1:0] a;
        logic [MUL_XLEN-1:0] b;
        logic                owner;
    } req_t;

endpackage

// File: rtl/mul_rr_arb.sv
// 2-way grant for the multiplier front-end. Define MUL_ARB_RR_EN for
// round-robin (pointer register); otherwise fixed priority to requester 0.
module mul_rr_arb
    import mul_arb_pkg::*;
(
`ifdef MUL_ARB_RR_EN
    input  logic               clock,
    input  logic               reset,
    input  logic               advance,
`endif
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               gnt_idx
);

`ifdef MUL_ARB_RR_EN
    logic ptr;

    // Pointer moves to the side that did not just win.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            ptr <= 1'b0;
        else if (advance)
            ptr <= ~gnt_idx;
    end

    always_comb begin
        gnt_idx = (req[0] && req[1]) ? ptr : req[1];
        grant   = '0;
        if (|req)
            grant[gnt_idx] = 1'b1;
    end
`else
    always_comb begin
        gnt_idx = ~req[0];
        grant   = req[0] ? 2'b01 : {req[1], 1'b0};
    end
`endif

endmodule

// File: rtl/mul_arb.sv
// Arbitrates two requesters onto one shared multiplier, one op in flight.
// MUL_ARB_RR_EN selects round-robin instead of fixed-priority grant.
module mul_arb
    import mul_arb_pkg::*;
#(
    parameter int XLEN = MUL_XLEN
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_sign,
    input  logic              req0_hi,
    input  logic [XLEN-1:0]   req0_a,
    input  logic [XLEN-1:0]   req0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_sign,
    input  logic              req1_hi,
    input  logic [XLEN-1:0]   req1_a,
    input  logic [XLEN-1:0]   req1_b,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [XLEN-1:0]   rsp0_data,

    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [XLEN-1:0]   rsp1_data,

    output logic              mul_in_valid,
    input  logic              mul_in_ready,
    output logic [1:0]        mul_sign,
    output logic [XLEN-1:0]   mul_a,
    output logic [XLEN-1:0]   mul_b,
    output logic              mul_flush,

    input  logic              mul_out_valid,
    output logic              mul_out_ready,
    input  logic [2*XLEN-1:0] mul_out_prod
);

    state_e               state, state_nxt;
    req_t                 cur, req_sel;
    logic [XLEN-1:0]      rsp_data;
    logic [NUM_REQ-1:0]   grant, req_rdy, rsp_vld;
    logic                 gnt_idx, accept, rsp_hs;

    mul_rr_arb u_arb (
`ifdef MUL_ARB_RR_EN
        .clock   (clock),
        .reset   (reset),
        .advance (accept),
`endif
        .req     ({req1_valid, req0_valid}),
        .grant   (grant),
        .gnt_idx (gnt_idx)
    );

    assign accept = |(req_rdy & {req1_valid, req0_valid});
    assign rsp_hs = |(rsp_vld & {rsp1_ready, rsp0_ready});

    always_comb begin
        req_sel = '0;
        if (gnt_idx) begin
            req_sel.sign  = req1_sign;
            req_sel.hi    = req1_hi;
            req_sel.a     = req1_a;
            req_sel.b     = req1_b;
            req_sel.owner = 1'b1;
        end else begin
            req_sel.sign  = req0_sign;
            req_sel.hi    = req0_hi;
            req_sel.a     = req0_a;
            req_sel.b     = req0_b;
            req_sel.owner = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (accept)        state_nxt = S_ISSUE;
                S_ISSUE: if (mul_in_ready)  state_nxt = S_WAIT;
                S_WAIT:  if (mul_out_valid) state_nxt = S_RESP;
                S_RESP:  if (rsp_hs)        state_nxt = S_IDLE;
                default:                    state_nxt = S_IDLE;
            endcase
        end
    end

    // Flush suppresses any handshake the requesters could complete this cycle.
    always_comb begin
        req_rdy       = '0;
        rsp_vld       = '0;
        mul_in_valid  = 1'b0;
        mul_out_ready = 1'b0;
        case (state)
            S_IDLE:  req_rdy = flush ? '0 : grant;
            S_ISSUE: mul_in_valid = 1'b1;
            S_WAIT:  mul_out_ready = 1'b1;
            S_RESP:  if (!flush) rsp_vld[cur.owner] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur      <= '0;
            rsp_data <= '0;
        end else begin
            if (accept)
                cur <= req_sel;
            if (state == S_WAIT && mul_out_valid && !flush)
                rsp_data <= cur.hi ? mul_out_prod[2*XLEN-1:XLEN] : mul_out_prod[XLEN-1:0];
        end
    end

    assign req0_ready = req_rdy[0];
    assign req1_ready = req_rdy[1];
    assign rsp0_valid = rsp_vld[0];
    assign rsp1_valid = rsp_vld[1];
    assign rsp0_data  = rsp_data;
    assign rsp1_data  = rsp_data;
    assign mul_sign   = cur.sign;
    assign mul_a      = cur.a;
    assign mul_b      = cur.b;
    assign mul_flush  = flush;

endmodule
